// File: rtl/maze_pkg.sv
// maze_pkg: game-outcome state encoding and default frame constants
package maze_pkg;
  typedef enum logic [1:0] {ARM = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_t;
  localparam int DEF_ARM_FRAMES  = 4;
  localparam int DEF_HIT_FRAMES  = 2;
  localparam int DEF_SAFE_FRAMES = 3;
  localparam int DEF_TIMER_W     = 16;
endpackage

// File: rtl/overlap_accumulator.sv
// overlap_accumulator: per-frame sticky OR of player-on-obstacle and player-on-safe pixels
module overlap_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic update_i,
  input  logic player_i,
  input  logic wall_any_i,
  input  logic border_i,
  input  logic safe_i,
  output logic frame_hit_o,
  output logic frame_safe_o
);
  logic hit_q, safe_q;
  // Outputs include the current pixel so the strobe cycle's pixel is part of the frame
  assign frame_hit_o  = hit_q | (player_i & (wall_any_i | border_i));
  assign frame_safe_o = safe_q | (player_i & safe_i);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      safe_q <= 1'b0;
    end else begin
      hit_q  <= !update_i & frame_hit_o;
      safe_q <= !update_i & frame_safe_o;
    end
  end
endmodule

// File: rtl/maze_outcome_fsm.sv
// maze_outcome_fsm: per-frame win/lose decision with spawn grace, debounce, level restart and play timer
module maze_outcome_fsm
  import maze_pkg::*;
#(
  parameter int ARM_FRAMES  = DEF_ARM_FRAMES,
  parameter int HIT_FRAMES  = DEF_HIT_FRAMES,
  parameter int SAFE_FRAMES = DEF_SAFE_FRAMES,
  parameter int TIMER_W     = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update_i,
  input  logic               player_i,
  input  logic               wall_any_i,
  input  logic               border_i,
  input  logic               safe_i,
  input  logic               levelselect_i,
  output logic               win_o,
  output logic               game_over_o,
  output logic [1:0]         state_o,
  output logic [TIMER_W-1:0] play_frames_o
);
  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int SW = $clog2(SAFE_FRAMES + 1);
  state_t             state_q, state_d;
  logic [AW-1:0]      arm_q, arm_d;
  logic [HW-1:0]      hit_q, hit_d, hit_inc;
  logic [SW-1:0]      safe_q, safe_d, safe_inc;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               win_q, win_d, go_q, go_d, lvl_q;
  logic               frame_hit, frame_safe, lvl_chg, arm_done;
  overlap_accumulator u_acc (
    .clk          (clk),
    .rst          (rst),
    .update_i     (update_i),
    .player_i     (player_i),
    .wall_any_i   (wall_any_i),
    .border_i     (border_i),
    .safe_i       (safe_i),
    .frame_hit_o  (frame_hit),
    .frame_safe_o (frame_safe)
  );
  assign lvl_chg  = lvl_q != levelselect_i;
  assign arm_done = arm_q == AW'(ARM_FRAMES - 1);
  // A hit frame breaks any safe streak, so overlap counts as hit only
  assign hit_inc  = frame_hit ? hit_q + HW'(1) : '0;
  assign safe_inc = (frame_safe & !frame_hit) ? safe_q + SW'(1) : '0;
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    hit_d   = hit_q;
    safe_d  = safe_q;
    timer_d = timer_q;
    if (lvl_chg) begin
      state_d = ARM;
      arm_d   = '0;
      hit_d   = '0;
      safe_d  = '0;
      timer_d = '0;
    end else if (update_i) begin
      case (state_q)
        ARM: begin
          arm_d   = arm_done ? '0 : arm_q + AW'(1);
          state_d = arm_done ? PLAY : ARM;
        end
        PLAY: begin
          hit_d   = hit_inc;
          safe_d  = safe_inc;
          timer_d = &timer_q ? timer_q : timer_q + TIMER_W'(1);
          state_d = hit_inc == HW'(HIT_FRAMES) ? LOSE :
                    safe_inc == SW'(SAFE_FRAMES) ? WIN : PLAY;
        end
        default: ;
      endcase
    end
    win_d = state_d == WIN;
    go_d  = state_d == LOSE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARM;
      arm_q   <= '0;
      hit_q   <= '0;
      safe_q  <= '0;
      timer_q <= '0;
      win_q   <= 1'b0;
      go_q    <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      hit_q   <= hit_d;
      safe_q  <= safe_d;
      timer_q <= timer_d;
      win_q   <= win_d;
      go_q    <= go_d;
      lvl_q   <= levelselect_i;
    end
  end
  assign win_o         = win_q;
  assign game_over_o   = go_q;
  assign state_o       = state_q;
  assign play_frames_o = timer_q;
endmodule

// File: tb/tb_maze_outcome_fsm.sv
// tb_maze_outcome_fsm: frame-table, corner-case and random checks against a frame-history model
module tb_maze_outcome_fsm;
  localparam int ARM = 4, HIT = 2, SAFE = 3, TW = 4;
  logic clk = 1'b0, rst;
  logic update_i, player_i, wall_any_i, border_i, safe_i, levelselect_i;
  logic win_o, game_over_o;
  logic [1:0] state_o;
  logic [TW-1:0] play_frames_o;
  int errors = 0, checks = 0;
  int m_frames, m_done, m_play;
  int m_hist[$];
  bit acc_hit, acc_safe, prev_lvl;

  typedef struct {
    bit hit, safe, lvl;
    int st, win, go, pf;
  } vec_t;
  vec_t tbl[19];

  always #5 clk = ~clk;

  maze_outcome_fsm #(.ARM_FRAMES(ARM), .HIT_FRAMES(HIT), .SAFE_FRAMES(SAFE), .TIMER_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .update_i      (update_i),
    .player_i      (player_i),
    .wall_any_i    (wall_any_i),
    .border_i      (border_i),
    .safe_i        (safe_i),
    .levelselect_i (levelselect_i),
    .win_o         (win_o),
    .game_over_o   (game_over_o),
    .state_o       (state_o),
    .play_frames_o (play_frames_o)
  );

  function automatic void m_restart();
    m_frames = 0;
    m_done   = 0;
    m_play   = 0;
    m_hist.delete();
  endfunction

  function automatic bit tail_all(int n, int v);
    if (m_hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++) if (m_hist[m_hist.size()-1-i] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_state();
    return m_done != 0 ? m_done : (m_frames < ARM ? 0 : 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".state"}, 32'(state_o), exp_state());
    chk({tag, ".win"}, 32'(win_o), int'(m_done == 2));
    chk({tag, ".game_over"}, 32'(game_over_o), int'(m_done == 3));
    chk({tag, ".play_frames"}, 32'(play_frames_o), m_play);
  endtask

  task automatic step(bit upd, bit pl, bit wa, bit bd, bit sf, bit lvl);
    int cls;
    @(negedge clk);
    update_i = upd; player_i = pl; wall_any_i = wa; border_i = bd; safe_i = sf; levelselect_i = lvl;
    acc_hit  |= pl & (wa | bd);
    acc_safe |= pl & sf;
    if (lvl != prev_lvl) m_restart();
    else if (upd && m_done == 0) begin
      if (m_frames < ARM) m_frames++;
      else begin
        cls = acc_hit ? 1 : (acc_safe ? 2 : 0);
        m_hist.push_back(cls);
        if (m_play < (1 << TW) - 1) m_play++;
        if (tail_all(HIT, 1)) m_done = 3;
        else if (tail_all(SAFE, 2)) m_done = 2;
      end
    end
    if (upd) begin
      acc_hit  = 1'b0;
      acc_safe = 1'b0;
    end
    prev_lvl = lvl;
    @(posedge clk);
    #1;
    chk_model("cycle");
  endtask

  task automatic frame(bit hit, bit safe, bit lvl);
    step(1'b0, hit, hit, 1'b0, 1'b0, lvl);
    step(1'b0, safe, 1'b0, 1'b0, safe, lvl);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lvl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    update_i = 0; player_i = 0; wall_any_i = 0; border_i = 0; safe_i = 0; levelselect_i = 0;
    prev_lvl = 0; acc_hit = 0; acc_safe = 0;
    m_restart();
    repeat (2) @(negedge clk);
    chk_model("reset");
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 2};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 3};
    tbl[7]  = '{1, 1, 0, 3, 0, 1, 4};
    tbl[8]  = '{0, 0, 0, 3, 0, 1, 4};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 1, 0, 0, 1};
    tbl[14] = '{1, 1, 1, 1, 0, 0, 2};
    tbl[15] = '{0, 1, 1, 1, 0, 0, 3};
    tbl[16] = '{0, 1, 1, 1, 0, 0, 4};
    tbl[17] = '{0, 1, 1, 2, 1, 0, 5};
    tbl[18] = '{1, 0, 1, 2, 1, 0, 5};
    do_reset();
    for (int i = 0; i < 19; i++) begin
      frame(tbl[i].hit, tbl[i].safe, tbl[i].lvl);
      chk($sformatf("tbl%0d.state", i), 32'(state_o), tbl[i].st);
      chk($sformatf("tbl%0d.win", i), 32'(win_o), tbl[i].win);
      chk($sformatf("tbl%0d.game_over", i), 32'(game_over_o), tbl[i].go);
      chk($sformatf("tbl%0d.play_frames", i), 32'(play_frames_o), tbl[i].pf);
    end
    // level change in the same cycle as an update: the update must not count as an arm frame
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lvlupd.state", 32'(state_o), 0);
    chk("lvlupd.win", 32'(win_o), 0);
    repeat (3) frame(1'b0, 1'b0, 1'b0);
    chk("lvlupd.arm3", 32'(state_o), 0);
    frame(1'b0, 1'b0, 1'b0);
    chk("lvlupd.play", 32'(state_o), 1);
    repeat (20) frame(1'b0, 1'b0, 1'b0);
    chk("sat.play_frames", 32'(play_frames_o), 15);
    chk("sat.state", 32'(state_o), 1);
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    chk("nonconsec.game_over", 32'(game_over_o), 0);
    // border-only hit on two consecutive frames
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("border.state", 32'(state_o), 3);
    chk("border.game_over", 32'(game_over_o), 1);
    do_reset();
    repeat (6) frame(1'b0, 1'b0, 1'b0);
    chk("prerst.play_frames", 32'(play_frames_o), 2);
    #1 rst = 1'b1;
    #1;
    chk("asyncrst.state", 32'(state_o), 0);
    chk("asyncrst.play_frames", 32'(play_frames_o), 0);
    chk("asyncrst.outs", 32'({win_o, game_over_o}), 0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit lv;
      lv = ($urandom_range(79) == 0) ? ~prev_lvl : prev_lvl;
      step($urandom_range(3) == 0, $urandom_range(5) == 0, 1'($urandom), $urandom_range(3) == 0,
           1'($urandom), lv);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
